// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel clock-enable in, sync/blank/position out.
// The generator drives it through master; renderers observe through slave.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 10,
    parameter int FRAME_W = 8
);
    logic               pix_ce;
    logic               h_sync;
    logic               v_sync;
    logic               video_on;
    logic               vblank;
    logic [CNT_W-1:0]   pixel_x;
    logic [CNT_W-1:0]   pixel_y;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_count;

    modport master (
        input  pix_ce,
        output h_sync, v_sync, video_on, vblank,
        output pixel_x, pixel_y,
        output line_start, frame_start, frame_count
    );

    modport slave (
        input pix_ce,
        input h_sync, v_sync, video_on, vblank,
        input pixel_x, pixel_y,
        input line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator clocked by clk, advanced by pix_ce.
// Outputs are registered from next-state position: zero latency, no comb outputs.
module vga_timing_gen #(
    parameter int CNT_W    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int FRAME_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic H_ON = (H_POL != 0);
    localparam logic V_ON = (V_POL != 0);

    logic [CNT_W-1:0]   r_h;
    logic [CNT_W-1:0]   r_v;
    logic               r_h_sync;
    logic               r_v_sync;
    logic               r_video_on;
    logic               r_vblank;
    logic [CNT_W-1:0]   r_pix_x;
    logic [CNT_W-1:0]   r_pix_y;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_cnt;

    logic [CNT_W-1:0]   w_h_nxt;
    logic [CNT_W-1:0]   w_v_nxt;
    logic               w_hs_on;
    logic               w_vs_on;
    logic               w_h_vis;
    logic               w_v_vis;
    logic               w_line;
    logic               w_frame;

    // Next raster position: step one pixel per pix_ce, wrap line then frame.
    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (bus.pix_ce) begin
            if (r_h < H_LAST) begin
                w_h_nxt = r_h + 1'b1;
            end else begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end
        end
    end

    // Decode of the upcoming position; strobes only on a real pix_ce step.
    always_comb begin
        w_hs_on = (w_h_nxt >= H_SS) && (w_h_nxt < H_SE);
        w_vs_on = (w_v_nxt >= V_SS) && (w_v_nxt < V_SE);
        w_h_vis = (w_h_nxt < H_ACT);
        w_v_vis = (w_v_nxt < V_ACT);
        w_line  = bus.pix_ce && (w_h_nxt == '0);
        w_frame = w_line && (w_v_nxt == '0);
    end

    // Position and registered outputs; reset parks on the last pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h           <= H_LAST;
            r_v           <= V_LAST;
            r_h_sync      <= ~H_ON;
            r_v_sync      <= ~V_ON;
            r_video_on    <= 1'b0;
            r_vblank      <= 1'b1;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_h_sync      <= w_hs_on ? H_ON : ~H_ON;
            r_v_sync      <= w_vs_on ? V_ON : ~V_ON;
            r_video_on    <= w_h_vis && w_v_vis;
            r_vblank      <= ~w_v_vis;
            r_pix_x       <= (w_h_vis && w_v_vis) ? w_h_nxt : '0;
            r_pix_y       <= w_v_vis ? w_v_nxt : '0;
            r_line_start  <= w_line;
            r_frame_start <= w_frame;
            if (w_frame) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign bus.h_sync      = r_h_sync;
    assign bus.v_sync      = r_v_sync;
    assign bus.video_on    = r_video_on;
    assign bus.vblank      = r_vblank;
    assign bus.pixel_x     = r_pix_x;
    assign bus.pixel_y     = r_pix_y;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_count = r_frame_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode and a tiny
// inverted-polarity mode (16x10 total, FRAME_W=2) for whole-frame checks.
module tb_vga_timing_gen;
    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) bus0 ();
    vga_timing_gen_if #(.CNT_W(5),  .FRAME_W(2)) bus1 ();

    vga_timing_gen dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    vga_timing_gen #(
        .CNT_W(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1), .V_POL(1), .FRAME_W(2)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   k;
        logic hs;
        logic vs;
        logic von;
        logic vbl;
        int   px;
        int   py;
        logic ls;
        logic fs;
        int   fc;
    } vec_t;

    vec_t t0[11];
    vec_t t1[17];

    function automatic vec_t mk(int k, logic hs, logic vs, logic von,
                                logic vbl, int px, int py, logic ls,
                                logic fs, int fc);
        vec_t r;
        r.k = k; r.hs = hs; r.vs = vs; r.von = von; r.vbl = vbl;
        r.px = px; r.py = py; r.ls = ls; r.fs = fs; r.fc = fc;
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rec(string tag, vec_t e, logic hs, logic vs,
                           logic von, logic vbl, logic [31:0] px,
                           logic [31:0] py, logic ls, logic fs,
                           logic [31:0] fc);
        string p;
        p = $sformatf("%s k=%0d", tag, e.k);
        chk({p, " h_sync"},      32'(hs),  32'(e.hs));
        chk({p, " v_sync"},      32'(vs),  32'(e.vs));
        chk({p, " video_on"},    32'(von), 32'(e.von));
        chk({p, " vblank"},      32'(vbl), 32'(e.vbl));
        chk({p, " pixel_x"},     px,       e.px);
        chk({p, " pixel_y"},     py,       e.py);
        chk({p, " line_start"},  32'(ls),  32'(e.ls));
        chk({p, " frame_start"}, 32'(fs),  32'(e.fs));
        chk({p, " frame_count"}, fc,       e.fc);
    endtask

    task automatic step0(logic p);
        bus0.pix_ce = p;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(logic p);
        bus1.pix_ce = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus0.pix_ce = 1'b0;
        bus1.pix_ce = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk0(string tag, vec_t e);
        chk_rec(tag, e, bus0.h_sync, bus0.v_sync, bus0.video_on,
                bus0.vblank, 32'(bus0.pixel_x), 32'(bus0.pixel_y),
                bus0.line_start, bus0.frame_start, 32'(bus0.frame_count));
    endtask

    task automatic chk1(string tag, vec_t e);
        chk_rec(tag, e, bus1.h_sync, bus1.v_sync, bus1.video_on,
                bus1.vblank, 32'(bus1.pixel_x), 32'(bus1.pixel_y),
                bus1.line_start, bus1.frame_start, 32'(bus1.frame_count));
    endtask

    // Walk dut0 through table t0, one pix_ce edge every gap clocks.
    task automatic run0(int gap);
        int edges;
        string tag;
        edges = 0;
        tag = $sformatf("d0 gap%0d", gap);
        for (int i = 0; i < 11; i++) begin
            while (edges < t0[i].k) begin
                repeat (gap - 1) step0(1'b0);
                step0(1'b1);
                edges++;
            end
            chk0(tag, t0[i]);
            if (gap > 1) begin
                step0(1'b0);
                chk({tag, " hold line_start"}, 32'(bus0.line_start), 0);
                chk({tag, " hold frame_start"}, 32'(bus0.frame_start), 0);
                chk({tag, " hold pixel_x"}, 32'(bus0.pixel_x), t0[i].px);
            end
        end
    endtask

    initial begin
        vec_t r0;
        vec_t r1;
        int edges;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        bus0.pix_ce = 1'b0;
        bus1.pix_ce = 1'b0;

        //   k    hs vs von vbl px   py ls fs fc
        t0[0]  = mk(1,   1, 1, 1, 0, 0,   0, 1, 1, 1);
        t0[1]  = mk(2,   1, 1, 1, 0, 1,   0, 0, 0, 1);
        t0[2]  = mk(640, 1, 1, 1, 0, 639, 0, 0, 0, 1);
        t0[3]  = mk(641, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        t0[4]  = mk(656, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        t0[5]  = mk(657, 0, 1, 0, 0, 0,   0, 0, 0, 1);
        t0[6]  = mk(752, 0, 1, 0, 0, 0,   0, 0, 0, 1);
        t0[7]  = mk(753, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        t0[8]  = mk(800, 1, 1, 0, 0, 0,   0, 0, 0, 1);
        t0[9]  = mk(801, 1, 1, 1, 0, 0,   1, 1, 0, 1);
        t0[10] = mk(802, 1, 1, 1, 0, 1,   1, 0, 0, 1);

        //   k    hs vs von vbl px py ls fs fc
        t1[0]  = mk(1,   0, 0, 1, 0, 0, 0, 1, 1, 1);
        t1[1]  = mk(10,  0, 0, 0, 0, 0, 0, 0, 0, 1);
        t1[2]  = mk(11,  1, 0, 0, 0, 0, 0, 0, 0, 1);
        t1[3]  = mk(13,  1, 0, 0, 0, 0, 0, 0, 0, 1);
        t1[4]  = mk(14,  0, 0, 0, 0, 0, 0, 0, 0, 1);
        t1[5]  = mk(96,  0, 0, 0, 0, 0, 5, 0, 0, 1);
        t1[6]  = mk(97,  0, 0, 0, 1, 0, 0, 1, 0, 1);
        t1[7]  = mk(112, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        t1[8]  = mk(113, 0, 1, 0, 1, 0, 0, 1, 0, 1);
        t1[9]  = mk(144, 0, 1, 0, 1, 0, 0, 0, 0, 1);
        t1[10] = mk(145, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        t1[11] = mk(160, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        t1[12] = mk(161, 0, 0, 1, 0, 0, 0, 1, 1, 2);
        t1[13] = mk(321, 0, 0, 1, 0, 0, 0, 1, 1, 3);
        t1[14] = mk(481, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        t1[15] = mk(482, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        t1[16] = mk(550, 0, 0, 1, 0, 5, 4, 0, 0, 0);

        r0 = mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        r1 = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        do_reset();
        repeat (10) step0(1'b0);
        chk0("reset0", r0);
        chk1("reset1", r1);

        run0(1);

        do_reset();
        run0(4);

        do_reset();
        edges = 0;
        for (int i = 0; i < 17; i++) begin
            while (edges < t1[i].k) begin
                step1(1'b1);
                edges++;
            end
            chk1("d1", t1[i]);
        end

        #2;
        rst = 1'b1;
        #1;
        chk1("async rst", r1);
        chk("async rst d0 frame_count", 32'(bus0.frame_count), 0);
        chk("async rst d0 vblank", 32'(bus0.vblank), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step1(1'b1);
        chk1("after rst", t1[0]);
        step1(1'b0);
        chk("after rst strobe clr", 32'(bus1.frame_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
